// File: rtl/sweep_pkg.sv
// Shared definitions for the pattern sweep capture block: controller states
// and the MISR feedback polynomial.
package sweep_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    SAMPLE = 3'd2,
    EMIT   = 3'd3,
    DONE   = 3'd4
  } sweep_state_e;

  // CCITT feedback taps for a 16-bit signature; narrower signatures use the
  // low bits.
  localparam logic [15:0] POLY = 16'h1021;

endpackage : sweep_pkg

// File: rtl/sweep_misr.sv
// Multiple-input signature register: folds one response word per enabled
// cycle into a running signature. A synchronous clear restarts it from zero.
module sweep_misr
  import sweep_pkg::*;
#(
  parameter int SIG_W = 16,
  parameter int DIN_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic [DIN_W-1:0] din,
  output logic [SIG_W-1:0] sig
);

  localparam logic [SIG_W-1:0] POLY_W = SIG_W'(POLY);

  logic [SIG_W-1:0] sig_d;
  logic [SIG_W-1:0] sig_q;

  // Next signature: shift, conditional polynomial feedback, fold in data.
  always_comb begin
    sig_d = sig_q;
    if (clear) begin
      sig_d = '0;
    end else if (en) begin
      sig_d = (sig_q << 1) ^ (sig_q[SIG_W-1] ? POLY_W : '0) ^ SIG_W'(din);
    end
  end

  // Signature register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sig_q <= '0;
    else     sig_q <= sig_d;
  end

  assign sig = sig_q;

endmodule : sweep_misr

// File: rtl/pattern_sweep_capture.sv
// Exhaustive stimulus sweep: drives every N_W-bit pattern to an external
// DUT, lets it settle, captures the response, hands each (pattern, response)
// record to a logger over valid/ready and compacts all responses into a MISR.
module pattern_sweep_capture
  import sweep_pkg::*;
#(
  parameter int N_W        = 3,
  parameter int OUT_W      = 1,
  parameter int SIG_W      = 16,
  parameter int SETTLE_CYC = 1
) (
  input  logic             CK,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  output logic [N_W-1:0]   N_out,
  input  logic [OUT_W-1:0] dut_out,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [N_W-1:0]   resp_pattern,
  output logic [OUT_W-1:0] resp_bits,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] sig
);

  localparam int                CNT_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [N_W-1:0]    LAST_PAT = '1;

  sweep_state_e     state_d, state_q;
  logic [N_W-1:0]   pattern_d, pattern_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [N_W-1:0]   resp_pattern_d, resp_pattern_q;
  logic [OUT_W-1:0] resp_bits_d, resp_bits_q;
  logic             misr_clear;
  logic             misr_en;

  // Next-state and datapath updates; abort overrides every state.
  // NOTE: every signal assigned here gets a default first so that no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d        = state_q;
    pattern_d      = pattern_q;
    cnt_d          = cnt_q;
    resp_pattern_d = resp_pattern_q;
    resp_bits_d    = resp_bits_q;
    misr_clear     = 1'b0;
    misr_en        = 1'b0;

    if (abort) begin
      state_d   = IDLE;
      pattern_d = '0;
      cnt_d     = '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d    = SETTLE;
            pattern_d  = '0;
            cnt_d      = '0;
            misr_clear = 1'b1;
          end
        end
        SETTLE: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = SAMPLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        SAMPLE: begin
          resp_pattern_d = pattern_q;
          resp_bits_d    = dut_out;
          misr_en        = 1'b1;
          state_d        = EMIT;
        end
        EMIT: begin
          if (resp_ready) begin
            if (pattern_q == LAST_PAT) begin
              state_d = DONE;
            end else begin
              pattern_d = pattern_q + N_W'(1);
              state_d   = SETTLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      pattern_q      <= '0;
      cnt_q          <= '0;
      resp_pattern_q <= '0;
      resp_bits_q    <= '0;
    end else begin
      state_q        <= state_d;
      pattern_q      <= pattern_d;
      cnt_q          <= cnt_d;
      resp_pattern_q <= resp_pattern_d;
      resp_bits_q    <= resp_bits_d;
    end
  end

  sweep_misr #(
    .SIG_W (SIG_W),
    .DIN_W (OUT_W)
  ) u_misr (
    .clk   (CK),
    .rst   (reset),
    .clear (misr_clear),
    .en    (misr_en),
    .din   (dut_out),
    .sig   (sig)
  );

  assign N_out        = pattern_q;
  assign resp_pattern = resp_pattern_q;
  assign resp_bits    = resp_bits_q;
  assign resp_valid   = (state_q == EMIT);
  assign busy         = (state_q == SETTLE) || (state_q == SAMPLE) || (state_q == EMIT);
  assign done         = (state_q == DONE);

endmodule : pattern_sweep_capture
